dma_cmd_sequencer: RTL and testbench
====================================

// Module: dma_cmd_sequencer
// PURPOSE
//  Upstream command stage for the DMA: takes 32-bit command words from the JTAG side and decodes write/read requests.
//  Write: stores the data words in the shared buffer, then kicks the DMA. Read: kicks the DMA, then fetches buffer word 0.
//  Every accepted command returns exactly one response word to the JTAG side, except NOP.
//  Includes a watchdog so a stalled DMA cannot hang the JTAG link.
// PARAMETERS
//  BufAddrWidth  9        buffer word-address width (matches DMA bufferAddress)
//  TimeoutCycles 4096     max cycles waiting for dma_done before abort
// PORTS
//  clock              in   1   system clock, all logic on rising edge
//  n_reset            in   1   asynchronous, active-low reset
//  cmd_data           in   32  command word from JTAG side
//  cmd_valid          in   1   cmd_data valid
//  cmd_ready          out  1   word accepted when cmd_valid&cmd_ready
//  rsp_data           out  32  response word
//  rsp_status         out  3   {illegal, timeout, bus_error}
//  rsp_valid          out  1   response valid, held until rsp_ready
//  rsp_ready          in   1   JTAG side consumes response
//  ipcore_dataReady   out  1   1-cycle pulse: buffer loaded, DMA write may start
//  ipcore_readReady   out  1   1-cycle pulse: DMA read may start
//  ipcore_byteEnable  out  4   byte enables of current command
//  ipcore_address_to_read out 32 bus address of current command
//  dma_done           in   1   1-cycle pulse from DMA: transaction finished
//  dma_error          in   1   bus error seen by DMA (sampled while waiting)
//  buf_address        out  BufAddrWidth  buffer port address
//  buf_dataIn         out  32  buffer write data
//  buf_writeEnable    out  1   buffer write strobe
//  buf_dataOut        in   32  buffer read data, 1-cycle latency after address
// BEHAVIOUR
//  Reset: state IDLE; every output 0, except cmd_ready=1. Internal counters and flags 0.
//  Header word: [31:30] op (00 NOP, 01 WRITE, 10 READ, 11 illegal), [29:26] byteEnable, [7:0] count.
//  States: IDLE, ADDR, DATA, KICK_WR, WAIT, KICK_RD, WAIT_RD, BUF_RD, BUF_LAT, RESP.
//  IDLE: cmd_ready=1; on accepted header latch op, byteEnable, count.
//    NOP -> stays IDLE, no response. Illegal op, or WRITE with count=0 -> RESP with status=3'b100, rsp_data=0.
//    Otherwise -> ADDR.
//  ADDR: cmd_ready=1; accepted word latched into ipcore_address_to_read. WRITE->DATA (index=0); READ->KICK_RD.
//  DATA: cmd_ready=1; each accepted word written in the same cycle:
//    buf_writeEnable=1, buf_address=index, buf_dataIn=cmd_data.
//    After word count-1 -> KICK_WR. Index width BufAddrWidth; count>2^BufAddrWidth is flagged illegal at the header.
//  KICK_WR: ipcore_dataReady=1 for exactly one cycle -> WAIT. KICK_RD: ipcore_readReady=1 for one cycle -> WAIT_RD.
//  ipcore_address_to_read and ipcore_byteEnable hold their values from header/ADDR until the next header.
//  WAIT/WAIT_RD: cmd_ready=0; watchdog counts from 0.
//    dma_error -> RESP, status bit0 set.
//    Count reaches TimeoutCycles-1 with no dma_done -> RESP, status bit1 set. Both together -> bits 0 and 1 set.
//    dma_done: WAIT -> RESP, status=0, rsp_data=count; WAIT_RD -> BUF_RD.
//    dma_done and dma_error in the same cycle: error wins.
//  BUF_RD: buf_address=0 -> BUF_LAT. BUF_LAT: capture buf_dataOut into rsp_data -> RESP.
//  RESP: rsp_valid=1; rsp_data and rsp_status stable while rsp_ready=0.
//    Handshake -> IDLE, rsp_valid=0 next cycle. On error/timeout, rsp_data=0.
//  cmd_ready=0 in every state except IDLE, ADDR, DATA. Input words are never dropped or duplicated.
//  Reset asserted mid-command: immediate return to IDLE; partially written buffer contents are not cleared.
//  Latency: DMA kick occurs 1 cycle after the last data word (write) or the address word (read).
// TESTING
//  WRITE count=3 be=F addr=0x40000010, data A,B,C -> buf[0..2]=A,B,C; one dataReady pulse;
//    dma_done -> rsp_data=3, status=0.
//  READ be=F addr=0x40000020 -> one readReady pulse, address held; dma_done, then buf[0]=0x12345678
//    -> rsp_data=0x12345678 two cycles later.
//  READ with no dma_done -> rsp_status=3'b010 exactly TimeoutCycles cycles after the kick.
//  dma_error and dma_done in the same WAIT cycle -> status=3'b001, rsp_data=0.
//  Header op=11, and WRITE count=0 -> immediate response, status=3'b100; following NOP -> no response.
//  rsp_ready low 10 cycles -> response held stable; n_reset low during DATA -> IDLE, all outputs at reset values.

Source files
------------

// File: rtl/dma_cmd_sequencer.sv
// dma_cmd_sequencer: decodes JTAG-side command words into DMA write/read
// transactions on the shared buffer, returns one response word per command
// (NOP excepted), and aborts through a watchdog if the DMA never finishes.
module dma_cmd_sequencer #(
    parameter int BufAddrWidth  = 9,
    parameter int TimeoutCycles = 4096
) (
    input  logic                    clock,
    input  logic                    n_reset,
    input  logic [31:0]             cmd_data,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    output logic [31:0]             rsp_data,
    output logic [2:0]              rsp_status,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    ipcore_dataReady,
    output logic                    ipcore_readReady,
    output logic [3:0]              ipcore_byteEnable,
    output logic [31:0]             ipcore_address_to_read,
    input  logic                    dma_done,
    input  logic                    dma_error,
    output logic [BufAddrWidth-1:0] buf_address,
    output logic [31:0]             buf_dataIn,
    output logic                    buf_writeEnable,
    input  logic [31:0]             buf_dataOut
);

    localparam int WdWidth = $clog2(TimeoutCycles + 1);
    // The counter starts at 0 on the first wait cycle and the abort is decided
    // when its next value would reach TimeoutCycles-1, so the response appears
    // exactly TimeoutCycles cycles after the kick pulse.
    localparam logic [WdWidth-1:0] WdLast = WdWidth'(TimeoutCycles - 2);

    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpRead  = 2'b10;

    typedef enum logic [3:0] {
        IDLE, ADDR, DATA, KICK_WR, WAIT, KICK_RD, WAIT_RD, BUF_RD, BUF_LAT, RESP
    } state_t;

    state_t                  state;
    logic [1:0]              op;
    logic [7:0]              count;
    logic [BufAddrWidth-1:0] wr_index;
    logic [WdWidth-1:0]      wdog;

    logic hdr_op_bad;
    logic hdr_write_bad;
    logic hdr_illegal;
    logic last_word;
    logic wd_expire;
    logic wd_timeout;

    // Handshake and buffer-write strobes must act in the same cycle as the word,
    // so they are decoded straight from the state register.
    assign cmd_ready       = (state == IDLE) || (state == ADDR) || (state == DATA);
    assign buf_writeEnable = (state == DATA) && cmd_valid;
    assign buf_dataIn      = buf_writeEnable ? cmd_data : '0;
    // Outside DATA the port sits at word 0, which is also the BUF_RD fetch address.
    assign buf_address     = (state == DATA) ? wr_index : '0;

    assign hdr_op_bad    = (cmd_data[31:30] == 2'b11);
    assign hdr_write_bad = (cmd_data[31:30] == OpWrite) &&
                           ((cmd_data[7:0] == 8'd0) ||
                            (32'(cmd_data[7:0]) > (32'd1 << BufAddrWidth)));
    assign hdr_illegal   = hdr_op_bad || hdr_write_bad;
    assign last_word     = (32'(wr_index) + 32'd1 == 32'(count));
    assign wd_expire     = (wdog == WdLast);
    // A done pulse on the final wait cycle still counts as completion.
    assign wd_timeout    = wd_expire && !dma_done;

    // Command sequencer: state, latched command fields and all registered outputs.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state                  <= IDLE;
            op                     <= '0;
            count                  <= '0;
            wr_index               <= '0;
            wdog                   <= '0;
            rsp_data               <= '0;
            rsp_status             <= '0;
            rsp_valid              <= 1'b0;
            ipcore_dataReady       <= 1'b0;
            ipcore_readReady       <= 1'b0;
            ipcore_byteEnable      <= '0;
            ipcore_address_to_read <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    op                <= cmd_data[31:30];
                    ipcore_byteEnable <= cmd_data[29:26];
                    count             <= cmd_data[7:0];
                    if (hdr_illegal) begin
                        rsp_data   <= '0;
                        rsp_status <= 3'b100;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (cmd_data[31:30] != OpNop) begin
                        state <= ADDR;
                    end
                end
                ADDR: if (cmd_valid) begin
                    ipcore_address_to_read <= cmd_data;
                    if (op == OpWrite) begin
                        wr_index <= '0;
                        state    <= DATA;
                    end else if (op == OpRead) begin
                        ipcore_readReady <= 1'b1;
                        state            <= KICK_RD;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: if (cmd_valid) begin
                    wr_index <= wr_index + 1'b1;
                    if (last_word) begin
                        ipcore_dataReady <= 1'b1;
                        state            <= KICK_WR;
                    end
                end
                KICK_WR: begin
                    ipcore_dataReady <= 1'b0;
                    wdog             <= '0;
                    state            <= WAIT;
                end
                KICK_RD: begin
                    ipcore_readReady <= 1'b0;
                    wdog             <= '0;
                    state            <= WAIT_RD;
                end
                WAIT, WAIT_RD: begin
                    wdog <= wdog + 1'b1;
                    // Error outranks done; timeout only when no done arrived.
                    if (dma_error || wd_timeout) begin
                        rsp_data   <= '0;
                        rsp_status <= {1'b0, wd_timeout, dma_error};
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (dma_done) begin
                        if (state == WAIT) begin
                            rsp_data   <= 32'(count);
                            rsp_status <= 3'b000;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            state <= BUF_RD;
                        end
                    end
                end
                BUF_RD: state <= BUF_LAT;
                BUF_LAT: begin
                    rsp_data   <= buf_dataOut;
                    rsp_status <= 3'b000;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Directed bench for dma_cmd_sequencer: a small buffer RAM model plus
// hand-computed expectations for each command scenario.
module tb_dma_cmd_sequencer;

    localparam int AW = 9;
    localparam int TO = 4096;

    logic          clock = 1'b0;
    logic          n_reset = 1'b1;
    logic [31:0]   cmd_data = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [31:0]   rsp_data;
    logic [2:0]    rsp_status;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          ipcore_dataReady;
    logic          ipcore_readReady;
    logic [3:0]    ipcore_byteEnable;
    logic [31:0]   ipcore_address_to_read;
    logic          dma_done = 1'b0;
    logic          dma_error = 1'b0;
    logic [AW-1:0] buf_address;
    logic [31:0]   buf_dataIn;
    logic          buf_writeEnable;
    logic [31:0]   buf_dataOut;

    logic [31:0]   mem [0:(1<<AW)-1];
    int total = 0;
    int bad = 0;
    int dr_pulses = 0;
    int rr_pulses = 0;

    dma_cmd_sequencer #(.BufAddrWidth(AW), .TimeoutCycles(TO)) dut (
        .clock(clock), .n_reset(n_reset),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .ipcore_dataReady(ipcore_dataReady), .ipcore_readReady(ipcore_readReady),
        .ipcore_byteEnable(ipcore_byteEnable), .ipcore_address_to_read(ipcore_address_to_read),
        .dma_done(dma_done), .dma_error(dma_error),
        .buf_address(buf_address), .buf_dataIn(buf_dataIn),
        .buf_writeEnable(buf_writeEnable), .buf_dataOut(buf_dataOut)
    );

    always #5 clock = ~clock;

    // Buffer RAM model with one cycle of read latency.
    always @(posedge clock) begin
        if (buf_writeEnable) mem[buf_address] <= buf_dataIn;
        buf_dataOut <= mem[buf_address];
    end

    // Count kick pulses as seen by the DMA on each rising edge.
    always @(posedge clock) begin
        if (ipcore_dataReady) dr_pulses <= dr_pulses + 1;
        if (ipcore_readReady) rr_pulses <= rr_pulses + 1;
    end

    // Present one word from a falling edge and hold it until accepted.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        cmd_data = w; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin @(negedge clock); n++; end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL send_accept word=%h cmd_ready=%b required=1", w, cmd_ready);
        end
        @(negedge clock);
        cmd_valid = 1'b0; cmd_data = '0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic pulse_done(input logic err);
        dma_done = 1'b1; dma_error = err;
        @(negedge clock);
        dma_done = 1'b0; dma_error = 1'b0;
    endtask

    task automatic test_reset();
        n_reset = 1'b1;
        #2 n_reset = 1'b0;
        cmd_valid = 1'b1; cmd_data = 32'hFFFF_FFFF;
        repeat (2) @(negedge clock);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_data !== 32'h0 || rsp_status !== 3'b000) begin bad++; $display("FAIL reset_rsp got=%h/%b exp=0/000", rsp_data, rsp_status); end
        total++; if (ipcore_dataReady !== 1'b0 || ipcore_readReady !== 1'b0) begin bad++; $display("FAIL reset_kicks got=%b%b exp=00", ipcore_dataReady, ipcore_readReady); end
        total++; if (ipcore_byteEnable !== 4'h0 || ipcore_address_to_read !== 32'h0) begin bad++; $display("FAIL reset_cmd_fields got=%h/%h exp=0/0", ipcore_byteEnable, ipcore_address_to_read); end
        total++; if (buf_writeEnable !== 1'b0 || buf_dataIn !== 32'h0 || buf_address !== '0) begin bad++; $display("FAIL reset_buf got=%b/%h/%h exp=0/0/0", buf_writeEnable, buf_dataIn, buf_address); end
        cmd_valid = 1'b0; cmd_data = '0;
        n_reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_write();
        int d0;
        d0 = dr_pulses;
        send(32'h7C00_0003); send(32'h4000_0010);
        send(32'hAAAA_0001); send(32'hBBBB_0002); send(32'hCCCC_0003);
        total++; if (ipcore_dataReady !== 1'b1) begin bad++; $display("FAIL write_kick got=%b exp=1", ipcore_dataReady); end
        total++; if (ipcore_byteEnable !== 4'hF || ipcore_address_to_read !== 32'h4000_0010) begin bad++; $display("FAIL write_fields got=%h/%h exp=f/40000010", ipcore_byteEnable, ipcore_address_to_read); end
        total++; if (mem[0] !== 32'hAAAA_0001 || mem[1] !== 32'hBBBB_0002 || mem[2] !== 32'hCCCC_0003) begin bad++; $display("FAIL write_buf got=%h %h %h exp=aaaa0001 bbbb0002 cccc0003", mem[0], mem[1], mem[2]); end
        @(negedge clock);
        total++; if (ipcore_dataReady !== 1'b0 || cmd_ready !== 1'b0) begin bad++; $display("FAIL write_wait got kick=%b ready=%b exp=0/0", ipcore_dataReady, cmd_ready); end
        repeat (3) @(negedge clock);
        pulse_done(1'b0);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd3 || rsp_status !== 3'b000) begin bad++; $display("FAIL write_rsp got=%b/%h/%b exp=1/3/000", rsp_valid, rsp_data, rsp_status); end
        total++; if (dr_pulses - d0 !== 1) begin bad++; $display("FAIL write_pulse_count got=%0d exp=1", dr_pulses - d0); end
        handshake();
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL write_release got=%b/%b exp=0/1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_read();
        int r0;
        send(32'h7C00_0001); send(32'h4000_0000); send(32'h1234_5678);
        @(negedge clock);
        pulse_done(1'b0);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd1) begin bad++; $display("FAIL read_preload_rsp got=%b/%h exp=1/1", rsp_valid, rsp_data); end
        handshake();
        r0 = rr_pulses;
        send(32'hBC00_0000); send(32'h4000_0020);
        total++; if (ipcore_readReady !== 1'b1 || ipcore_address_to_read !== 32'h4000_0020) begin bad++; $display("FAIL read_kick got=%b/%h exp=1/40000020", ipcore_readReady, ipcore_address_to_read); end
        @(negedge clock);
        total++; if (ipcore_readReady !== 1'b0) begin bad++; $display("FAIL read_kick_width got=%b exp=0", ipcore_readReady); end
        repeat (2) @(negedge clock);
        pulse_done(1'b0);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL read_early1 got=%b exp=0", rsp_valid); end
        @(negedge clock);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL read_early2 got=%b exp=0", rsp_valid); end
        @(negedge clock);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234_5678 || rsp_status !== 3'b000) begin bad++; $display("FAIL read_rsp got=%b/%h/%b exp=1/12345678/000", rsp_valid, rsp_data, rsp_status); end
        total++; if (rr_pulses - r0 !== 1 || ipcore_address_to_read !== 32'h4000_0020) begin bad++; $display("FAIL read_pulses_addr got=%0d/%h exp=1/40000020", rr_pulses - r0, ipcore_address_to_read); end
        handshake();
    endtask

    task automatic test_timeout();
        int n;
        send(32'hBC00_0000); send(32'h4000_0030);
        total++; if (ipcore_readReady !== 1'b1) begin bad++; $display("FAIL timeout_kick got=%b exp=1", ipcore_readReady); end
        n = 0;
        while (!rsp_valid && n < TO + 20) begin @(negedge clock); n++; end
        total++; if (n !== TO) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", n, TO); end
        total++; if (rsp_valid !== 1'b1 || rsp_status !== 3'b010 || rsp_data !== 32'h0) begin bad++; $display("FAIL timeout_rsp got=%b/%b/%h exp=1/010/0", rsp_valid, rsp_status, rsp_data); end
        handshake();
    endtask

    task automatic test_err_done();
        send(32'h7C00_0001); send(32'h4000_0040); send(32'h5555_AAAA);
        @(negedge clock);
        pulse_done(1'b1);
        total++; if (rsp_valid !== 1'b1 || rsp_status !== 3'b001 || rsp_data !== 32'h0) begin bad++; $display("FAIL err_done_rsp got=%b/%b/%h exp=1/001/0", rsp_valid, rsp_status, rsp_data); end
        handshake();
    endtask

    task automatic test_illegal();
        int d0, r0, seen;
        d0 = dr_pulses; r0 = rr_pulses;
        send(32'hC000_0005);
        total++; if (rsp_valid !== 1'b1 || rsp_status !== 3'b100 || rsp_data !== 32'h0 || cmd_ready !== 1'b0) begin bad++; $display("FAIL illegal_op got=%b/%b/%h/%b exp=1/100/0/0", rsp_valid, rsp_status, rsp_data, cmd_ready); end
        handshake();
        send(32'h7C00_0000);
        total++; if (rsp_valid !== 1'b1 || rsp_status !== 3'b100 || rsp_data !== 32'h0) begin bad++; $display("FAIL illegal_count0 got=%b/%b/%h exp=1/100/0", rsp_valid, rsp_status, rsp_data); end
        handshake();
        send(32'h3C00_0007);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) seen++;
            @(negedge clock);
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL nop_silent got=%0d cycles with response/stall exp=0", seen); end
        total++; if (dr_pulses !== d0 || rr_pulses !== r0) begin bad++; $display("FAIL illegal_no_kick got=%0d/%0d exp=%0d/%0d", dr_pulses, rr_pulses, d0, r0); end
    endtask

    task automatic test_hold();
        int unstable;
        send(32'h7C00_0002); send(32'h4000_0060); send(32'h0000_0011); send(32'h0000_0022);
        @(negedge clock);
        pulse_done(1'b0);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd2 || rsp_status !== 3'b000) unstable++;
            @(negedge clock);
        end
        total++; if (unstable !== 0) begin bad++; $display("FAIL hold_stable got=%0d unstable cycles exp=0", unstable); end
        handshake();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        send(32'h7C00_0004); send(32'h4000_0050); send(32'h0000_0033); send(32'h0000_0044);
        cmd_data = 32'h0000_0055; cmd_valid = 1'b1;
        #1 n_reset = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL midreset_hs got=%b/%b exp=1/0", cmd_ready, rsp_valid); end
        total++; if (buf_writeEnable !== 1'b0 || buf_dataIn !== 32'h0 || buf_address !== '0) begin bad++; $display("FAIL midreset_buf got=%b/%h/%h exp=0/0/0", buf_writeEnable, buf_dataIn, buf_address); end
        total++; if (ipcore_byteEnable !== 4'h0 || ipcore_address_to_read !== 32'h0) begin bad++; $display("FAIL midreset_fields got=%h/%h exp=0/0", ipcore_byteEnable, ipcore_address_to_read); end
        cmd_valid = 1'b0; cmd_data = '0;
        @(negedge clock);
        n_reset = 1'b1;
        @(negedge clock);
        send(32'h7C00_0001); send(32'h4000_0070); send(32'h0000_0077);
        @(negedge clock);
        pulse_done(1'b0);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd1 || mem[0] !== 32'h0000_0077) begin bad++; $display("FAIL midreset_recover got=%b/%h/%h exp=1/1/77", rsp_valid, rsp_data, mem[0]); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_err_done();
        test_illegal();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
